// File: rtl/led_bank.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM modes over a shared free-running counter.
// Optional per-channel pulse stretcher compiled in with `define LED_STROBE_EN.
module led_bank #(
    parameter int NUM_CH    = 2,
    parameter int CNT_W     = 24,
    parameter int BLINK_BIT = 20,
    parameter int PWM_W     = 8,
    parameter int TEST_BIT  = 0,
    parameter int HB_CH0    = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_wr_en,
    input  logic [3:0]        cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [PWM_W-1:0]  cfg_duty,
`ifdef LED_STROBE_EN
    input  logic [NUM_CH-1:0] led_strobe,
`endif
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] sys_leds,
    output logic              sys_test_port
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } mode_t;

    logic [CNT_W-1:0]  cnt;
    mode_t             mode_q [NUM_CH];
    logic [PWM_W-1:0]  duty_q [NUM_CH];
    logic [NUM_CH-1:0] led_next;
    logic              ch_valid;
    logic              wr_hit;

    assign ch_valid = ({1'b0, cfg_ch} < 5'(NUM_CH));
    assign wr_hit   = cfg_wr_en && ch_valid;

`ifdef LED_STROBE_EN
    logic [15:0]       stretch_q [NUM_CH];
    logic [NUM_CH-1:0] tail_q;

    // The 16-bit countdown covers 65535 cycles; tail_q extends the force by the final cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tail_q <= '0;
            for (int i = 0; i < NUM_CH; i++) stretch_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                tail_q[i] <= (stretch_q[i] == 16'd1);
                if (led_strobe[i])
                    stretch_q[i] <= 16'hFFFF;
                else if (stretch_q[i] != 16'd0)
                    stretch_q[i] <= stretch_q[i] - 16'd1;
            end
        end
    end
`endif

    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        led_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode_q[i])
                MODE_OFF:   led_next[i] = 1'b0;
                MODE_ON:    led_next[i] = 1'b1;
                MODE_BLINK: led_next[i] = cnt[BLINK_BIT];
                MODE_PWM:   led_next[i] = (cnt[PWM_W-1:0] < duty_q[i]);
                default:    led_next[i] = 1'b0;
            endcase
`ifdef LED_STROBE_EN
            if (stretch_q[i] != 16'd0 || tail_q[i]) led_next[i] = 1'b1;
`endif
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    // NOTE: mode/duty are a handful of flops rather than a RAM, so they take a reset value.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt           <= '0;
            cfg_ack       <= 1'b0;
            cfg_err       <= 1'b0;
            sys_leds      <= '0;
            sys_test_port <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= (HB_CH0 == 1 && i == 0) ? MODE_BLINK : MODE_OFF;
                duty_q[i] <= '0;
            end
        end else begin
            cnt           <= cnt + CNT_W'(1);
            cfg_ack       <= wr_hit;
            cfg_err       <= cfg_wr_en && !ch_valid;
            sys_leds      <= led_next;
            sys_test_port <= cnt[TEST_BIT];
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hit && cfg_ch == 4'(i)) begin
                    mode_q[i] <= mode_t'(cfg_mode);
                    duty_q[i] <= cfg_duty;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_bank.sv
// Scoreboard bench for led_bank: a behavioural model queues expected outputs per cycle,
// which are popped and compared one time unit after each rising edge.
module tb_led_bank;

    localparam int NUM_CH    = 2;
    localparam int CNT_W     = 24;
    localparam int BLINK_BIT = 4;
    localparam int PWM_W     = 8;
    localparam int TEST_BIT  = 0;
    localparam int HB_CH0    = 1;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              cfg_wr_en;
    logic [3:0]        cfg_ch;
    logic [1:0]        cfg_mode;
    logic [PWM_W-1:0]  cfg_duty;
    logic [NUM_CH-1:0] led_strobe;
    logic              cfg_ack;
    logic              cfg_err;
    logic [NUM_CH-1:0] sys_leds;
    logic              sys_test_port;

    led_bank #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BLINK_BIT(BLINK_BIT),
        .PWM_W(PWM_W), .TEST_BIT(TEST_BIT), .HB_CH0(HB_CH0)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .cfg_wr_en(cfg_wr_en),
        .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty),
`ifdef LED_STROBE_EN
        .led_strobe(led_strobe),
`endif
        .cfg_ack(cfg_ack),
        .cfg_err(cfg_err),
        .sys_leds(sys_leds),
        .sys_test_port(sys_test_port)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [NUM_CH-1:0] leds;
        logic              ack;
        logic              err;
        logic              test;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    logic [CNT_W-1:0] m_cnt;
    logic [1:0]       m_mode [NUM_CH];
    logic [PWM_W-1:0] m_duty [NUM_CH];
    int               m_force [NUM_CH];
    logic [NUM_CH-1:0] last_leds;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, push model prediction, advance model, then compare.
    task automatic step(input logic rst, input logic wr, input logic [3:0] ch,
                        input logic [1:0] mode, input logic [PWM_W-1:0] duty,
                        input logic [NUM_CH-1:0] strobe);
        exp_t e;
        exp_t got;
        @(negedge sys_clk);
        sys_rst = rst; cfg_wr_en = wr; cfg_ch = ch; cfg_mode = mode; cfg_duty = duty;
        led_strobe = strobe;

        e = '0;
        if (!rst) begin
            e.test = m_cnt[TEST_BIT];
            e.ack  = wr && (int'(ch) < NUM_CH);
            e.err  = wr && (int'(ch) >= NUM_CH);
            for (int i = 0; i < NUM_CH; i++) begin
                case (m_mode[i])
                    2'b00: e.leds[i] = 1'b0;
                    2'b01: e.leds[i] = 1'b1;
                    2'b10: e.leds[i] = m_cnt[BLINK_BIT];
                    default: e.leds[i] = (m_cnt[PWM_W-1:0] < m_duty[i]);
                endcase
`ifdef LED_STROBE_EN
                if (m_force[i] > 0) e.leds[i] = 1'b1;
`endif
            end
        end
        exp_q.push_back(e);

        if (rst) begin
            m_cnt = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_mode[i]  = (HB_CH0 == 1 && i == 0) ? 2'b10 : 2'b00;
                m_duty[i]  = '0;
                m_force[i] = 0;
            end
        end else begin
            m_cnt = m_cnt + 1;
            if (wr && int'(ch) < NUM_CH) begin
                m_mode[int'(ch)] = mode;
                m_duty[int'(ch)] = duty;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (strobe[i]) m_force[i] = 65536;
                else if (m_force[i] > 0) m_force[i]--;
            end
        end

        @(posedge sys_clk);
        #1;
        got = exp_q.pop_front();
        check("leds", 32'(sys_leds), 32'(got.leds));
        check("ack", 32'(cfg_ack), 32'(got.ack));
        check("err", 32'(cfg_err), 32'(got.err));
        check("test_port", 32'(sys_test_port), 32'(got.test));
        last_leds = sys_leds;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 2'b00, '0, '0);
    endtask

    task automatic write(input logic [3:0] ch, input logic [1:0] mode, input logic [PWM_W-1:0] duty);
        step(1'b0, 1'b1, ch, mode, duty, '0);
    endtask

    initial begin
        int hi;
        m_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_mode[i] = 2'b00; m_duty[i] = '0; m_force[i] = 0;
        end
        sys_rst = 1'b1; cfg_wr_en = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_duty = '0;
        led_strobe = '0;

        // Reset, with a write on the last reset cycle that must be discarded.
        step(1'b1, 1'b0, 4'd0, 2'b00, '0, '0);
        step(1'b1, 1'b0, 4'd0, 2'b00, '0, '0);
        step(1'b1, 1'b1, 4'd1, 2'b01, 8'd7, '0);
        check("reset_leds", 32'(sys_leds), 32'd0);

        // Heartbeat on ch0 toggling every 16 cycles, ch1 dark.
        idle(70);

        // PWM duty 64: exactly 64 highs in any 256-cycle window.
        write(4'd1, 2'b11, 8'd64);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            idle(1);
            hi += int'(last_leds[1]);
        end
        check("pwm64_highs", 32'(hi), 32'd64);

        write(4'd1, 2'b11, 8'd0);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            idle(1);
            hi += int'(last_leds[1]);
        end
        check("pwm0_highs", 32'(hi), 32'd0);

        write(4'd1, 2'b11, 8'd255);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            idle(1);
            hi += int'(last_leds[1]);
        end
        check("pwm255_highs", 32'(hi), 32'd255);

        // Out-of-range channel, then boundary channel 2, then ON/OFF back to back.
        write(4'd5, 2'b01, 8'd9);
        idle(3);
        write(4'd2, 2'b01, 8'd9);
        idle(2);
        write(4'd1, 2'b01, 8'd0);
        write(4'd1, 2'b00, 8'd0);
        idle(3);

        // Last of two back-to-back writes wins.
        write(4'd0, 2'b01, 8'd0);
        write(4'd0, 2'b00, 8'd0);
        idle(5);

        // Reset mid-PWM with a concurrent write.
        write(4'd1, 2'b11, 8'd128);
        idle(37);
        step(1'b1, 1'b1, 4'd1, 2'b01, 8'd3, '0);
        check("rst_mid_pwm_leds", 32'(sys_leds), 32'd0);
        idle(40);

`ifdef LED_STROBE_EN
        // Stretcher: strobes at t and t+100 keep ch1 lit through t+65636.
        write(4'd1, 2'b00, 8'd0);
        step(1'b0, 1'b0, 4'd0, 2'b00, '0, 2'b10);
        idle(99);
        step(1'b0, 1'b0, 4'd0, 2'b00, '0, 2'b10);
        hi = 0;
        for (int k = 0; k < 65540; k++) begin
            idle(1);
            hi += int'(last_leds[1]);
        end
        check("stretch_highs", 32'(hi), 32'd65536);
        check("stretch_end", 32'(last_leds[1]), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_bank.md
LED_BANK -- requirements
Module: led_bank

Interface
REQ-001 Parameter NUM_CH, default 2: number of LED channels, 1..16.
REQ-002 Parameter CNT_W, default 24: width of the shared free-running counter, 8..32.
REQ-003 Parameter BLINK_BIT, default 20: counter bit driving BLINK mode, less than CNT_W.
REQ-004 Parameter PWM_W, default 8: PWM resolution in bits, not greater than CNT_W.
REQ-005 Parameter TEST_BIT, default 0: counter bit routed to sys_test_port, less than CNT_W.
REQ-006 Parameter HB_CH0, default 1: when 1, channel 0 resets to BLINK mode; when 0, it resets to OFF.
REQ-007 Port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 Port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-009 Port cfg_wr_en, input, 1 bit: configuration write strobe, sampled every cycle.
REQ-010 Port cfg_ch, input, 4 bits: target channel index.
REQ-011 Port cfg_mode, input, 2 bits: mode code, where 00 = OFF, 01 = ON, 10 = BLINK, 11 = PWM.
REQ-012 Port cfg_duty, input, PWM_W bits: PWM duty value.
REQ-013 Port cfg_ack, output, 1 bit: one-cycle pulse for an accepted write.
REQ-014 Port cfg_err, output, 1 bit: one-cycle pulse for a rejected write.
REQ-015 Port sys_leds, output, NUM_CH bits: registered LED drives.
REQ-016 Port sys_test_port, output, 1 bit: registered copy of counter bit TEST_BIT.
REQ-017 Port led_strobe, input, NUM_CH bits: per-channel strobe; present only when LED_STROBE_EN is defined.

Function
REQ-018 The shared counter cnt (CNT_W bits) shall increment by 1 every cycle and wrap from all-ones to 0 with no flag.
REQ-019 Each channel shall hold a 2-bit mode register and a PWM_W-bit duty register.
REQ-020 Each cycle, sys_leds[i] shall register a value computed from cnt and channel i's registers as they stood before the edge; latency is 1 cycle.
- OFF: 0.
- ON: 1.
- BLINK: cnt[BLINK_BIT].
- PWM: 1 when cnt[PWM_W-1:0] < duty, else 0.
REQ-021 In PWM mode, duty 0 shall give constant 0, and duty 2^PWM_W-1 shall give high for 2^PWM_W-1 of every 2^PWM_W cycles.
REQ-022 A write is a cycle with cfg_wr_en=1; there is no backpressure, and one write can be accepted every cycle.
REQ-023 When a write has cfg_ch < NUM_CH, mode[cfg_ch] and duty[cfg_ch] shall update on that edge, and cfg_ack shall be 1 in the following cycle.
- Duty is written in every mode.
REQ-024 When a write has cfg_ch >= NUM_CH, no register shall change, and cfg_err shall be 1 in the following cycle.
REQ-025 cfg_ack and cfg_err shall never both be 1, and both shall be 0 in cycles following a cycle with no write.
REQ-026 A write accepted at edge t shall first affect sys_leds at edge t+1.
REQ-027 Back-to-back writes to the same channel shall resolve to the last one written.
REQ-028 sys_test_port shall equal cnt[TEST_BIT] delayed by one cycle.

Reset
REQ-029 While sys_rst=1 at an edge, the block shall load the following values; reset overrides any concurrent write or strobe.
- cnt = 0.
- All duty registers = 0.
- All modes = OFF, except channel 0 = BLINK when HB_CH0=1.
- sys_leds = 0, sys_test_port = 0, cfg_ack = 0, cfg_err = 0.
- All stretch counters = 0.
REQ-030 A write issued in the same cycle as sys_rst shall be discarded and shall produce no ack or error pulse.
REQ-031 Reset asserted mid-PWM or mid-strobe shall take effect at that edge; the first post-reset edge shall see cnt = 0.

Configuration
REQ-032 The macro LED_STROBE_EN shall compile in the strobe feature.
REQ-033 With LED_STROBE_EN defined, each channel shall add a 16-bit stretch counter.
- led_strobe[i]=1 loads the counter with 0xFFFF; this retriggers an active stretch.
- While the counter is non-zero it decrements each cycle and forces sys_leds[i]=1, overriding the mode.
- The counter saturates at 0.
- The LED is forced for exactly 65536 cycles after the last strobe.
REQ-034 Without LED_STROBE_EN, the led_strobe port, the stretch counters and the override logic shall be absent, and the behaviour is as in REQ-020.

Verification
REQ-035 Reset release with HB_CH0=1, CNT_W=24, BLINK_BIT=4: sys_leds[0] toggles every 16 cycles, and sys_leds[1]=0.
REQ-036 Write ch1 with PWM mode and duty 64 (PWM_W=8): sys_leds[1] is high for exactly 64 of every 256 cycles; then duty 0 gives constant low.
REQ-037 Write cfg_ch=5 with NUM_CH=2: cfg_err pulses once, cfg_ack=0, and the LEDs are unchanged.
REQ-038 Writes ON then OFF to ch1 in consecutive cycles: two cfg_ack pulses; sys_leds[1] is 1 for one cycle, then 0.
REQ-039 sys_rst pulsed while ch1 is in PWM: the next cycle shows sys_leds=2'b00, cnt=0 and ch1 mode OFF.
REQ-040 With LED_STROBE_EN, ch1 OFF, strobe at t and again at t+100: sys_leds[1]=1 from t+1 to t+65636, then 0.
